// File: rtl/calc_display_driver_if.sv
// ============================================================================
// Module      : calc_display_driver_if
// Description : Bundle between the calculator datapath outputs and the
//               8-digit 7-segment display driver (data in, display pins out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface calc_display_driver_if;
  logic [15:0] ToDisplay;  // value shown in hex on digits 3..0
  logic [3:0]  Flags;      // {N,Z,C,V}
  logic [2:0]  Status;     // calculator state code, shown on digit 7
  logic [7:0]  AN;         // digit enables, active low
  logic [6:0]  SEG;        // {g,f,e,d,c,b,a}, active low
  logic        DP;         // decimal point, active low
  logic [3:0]  LED;        // shadowed flags, active high

  // Data producer side: drives the values, observes the display pins
  modport master (
    output ToDisplay, Flags, Status,
    input  AN, SEG, DP, LED
  );

  // Display driver side
  modport slave (
    input  ToDisplay, Flags, Status,
    output AN, SEG, DP, LED
  );
endinterface

`default_nettype wire

// File: rtl/calc_display_driver.sv
// ============================================================================
// Module      : calc_display_driver
// Description : Time-multiplexed 8-digit common-anode 7-segment driver.
//               Digits 3..0 show a 16-bit value in hex, digit 7 the status
//               code, flags go to LEDs. Inputs are shadowed once per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_display_driver #(
  parameter int REFRESH_DIV = 100_000,  // clk cycles per digit slot (>=2)
  parameter bit LZ_SUPPRESS = 1'b1      // blank leading zero digits 3..1
) (
  input  logic                  clk,
  input  logic                  resetN,
  calc_display_driver_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'd7;
  localparam logic [2:0]       IDX_DP   = 3'd4;
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  // Scan state and frame shadow registers
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [15:0]      val_q, val_d;
  logic [3:0]       flg_q, flg_d;
  logic [2:0]       sts_q, sts_d;
  logic             cap_pending_q;

  // Registered display outputs
  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] led_q;

  logic       slot_end;
  logic       capture;
  logic [3:0] nibble;
  logic       blank;

  // Hex digit to active-low gfedcba pattern
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h40;  4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;  4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;  4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;  4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;  4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;  default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Slot divider, digit index and once-per-frame shadow capture.
  // Capture coincides with the 7->0 wrap so every frame uses one snapshot.
  always_comb begin
    slot_end  = (div_cnt_q == CNT_LAST);
    capture   = cap_pending_q | (slot_end & (idx_q == IDX_LAST));
    div_cnt_d = slot_end ? '0 : div_cnt_q + 1'b1;
    idx_d     = slot_end ? idx_q + 3'd1 : idx_q;  // 3-bit wrap 7->0
    val_d     = capture ? bus.ToDisplay : val_q;
    flg_d     = capture ? bus.Flags     : flg_q;
    sts_d     = capture ? bus.Status    : sts_q;
  end

  // Select the content of the currently enabled digit
  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    case (idx_q)
      3'd0: nibble = val_q[3:0];
      3'd1: begin
        nibble = val_q[7:4];
        blank  = LZ_SUPPRESS && (val_q[15:4] == 12'h000);
      end
      3'd2: begin
        nibble = val_q[11:8];
        blank  = LZ_SUPPRESS && (val_q[15:8] == 8'h00);
      end
      3'd3: begin
        nibble = val_q[15:12];
        blank  = LZ_SUPPRESS && (val_q[15:12] == 4'h0);
      end
      3'd7:    nibble = {1'b0, sts_q};
      default: blank  = 1'b1;
    endcase
    seg_d = blank ? SEG_BLANK : hex_seg(nibble);
    an_d  = ~(8'b1 << idx_q);
    dp_d  = (idx_q != IDX_DP);
  end

  // State and output registers; AN and SEG load on the same edge (no ghosting)
  always_ff @(posedge clk) begin
    if (!resetN) begin
      div_cnt_q     <= '0;
      idx_q         <= 3'd0;
      val_q         <= 16'h0000;
      flg_q         <= 4'h0;
      sts_q         <= 3'd0;
      cap_pending_q <= 1'b1;
      an_q          <= 8'hFF;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      led_q         <= 4'h0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      val_q         <= val_d;
      flg_q         <= flg_d;
      sts_q         <= sts_d;
      cap_pending_q <= 1'b0;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      led_q         <= flg_q;
    end
  end

  assign bus.AN  = an_q;
  assign bus.SEG = seg_q;
  assign bus.DP  = dp_q;
  assign bus.LED = led_q;

endmodule

`default_nettype wire
